ex_mem_stage: RTL

Execute-to-memory pipeline stage that sits directly downstream of the MIPS ALU. It registers the ALU result and flags together with the destination register, write-enable and PC into a two-entry skid buffer with valid/ready handshakes on both sides. It also sanitises NOOP results and, optionally, converts ADD/SUB overflow into a precise trap that records the faulting PC and squashes later instructions until the controller flushes.

---
 rtl/ex_mem_stage_if.sv | 38 +++
 rtl/ex_mem_stage.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/ex_mem_stage_if.sv
// Execute-to-memory bus: upstream handshake, ALU result fields, controller
// flush, downstream handshake and trap reporting.
// master: upstream ALU / controller / downstream side. slave: the stage.
interface ex_mem_stage_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] alu_res;
  logic        zero;
  logic        ovf;
  logic [3:0]  alu_ctl;
  logic [4:0]  rd_addr;
  logic        reg_wr;
  logic [31:0] pc;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_res;
  logic        out_zero;
  logic [4:0]  out_rd;
  logic        out_reg_wr;
  logic [31:0] out_pc;
  logic        trap;
  logic [31:0] epc;

  modport master (
    output in_valid, alu_res, zero, ovf, alu_ctl, rd_addr, reg_wr, pc,
           flush, out_ready,
    input  in_ready, out_valid, out_res, out_zero, out_rd, out_reg_wr,
           out_pc, trap, epc
  );

  modport slave (
    input  in_valid, alu_res, zero, ovf, alu_ctl, rd_addr, reg_wr, pc,
           flush, out_ready,
    output in_ready, out_valid, out_res, out_zero, out_rd, out_reg_wr,
           out_pc, trap, epc
  );
endinterface

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline stage: two-entry (head + skid) buffer with valid/ready on
// both sides, NOOP sanitising and optional precise overflow trap.
// Optional feature macro: OVF_TRAP_EN (ADD/SUB overflow -> trap, epc,
// squash of later inputs until flush). Undefined: trap/epc tie to 0.
// ALU codes: AND 0000, OR 0001, ADD 0010, XOR 0011, SLL 0100, SRL 0101,
// SUB 0110, SLT 0111, NOR 1100, NOOP 1110, ERROR 1111; others are unknown.
module ex_mem_stage (
  input  logic           clk,
  input  logic           rst_n,
  ex_mem_stage_if.slave  bus
);

  localparam logic [3:0] ALU_AND   = 4'b0000;
  localparam logic [3:0] ALU_OR    = 4'b0001;
  localparam logic [3:0] ALU_ADD   = 4'b0010;
  localparam logic [3:0] ALU_XOR   = 4'b0011;
  localparam logic [3:0] ALU_SLL   = 4'b0100;
  localparam logic [3:0] ALU_SRL   = 4'b0101;
  localparam logic [3:0] ALU_SUB   = 4'b0110;
  localparam logic [3:0] ALU_SLT   = 4'b0111;
  localparam logic [3:0] ALU_NOR   = 4'b1100;
  localparam logic [3:0] ALU_NOOP  = 4'b1110;

  typedef struct packed {
    logic [31:0] res;
    logic        zero;
    logic [4:0]  rd;
    logic        reg_wr;
    logic [31:0] pc;
  } entry_t;

  function automatic logic is_addsub(input logic [3:0] ctl);
    return (ctl == ALU_ADD) || (ctl == ALU_SUB);
  endfunction

  // NOOP results become a clean zero with no write; unknown/ERROR codes keep
  // their data but never write the register file; a trapping op never writes.
  function automatic entry_t sanitise(input entry_t raw, input logic [3:0] ctl,
                                      input logic kill_wr);
    entry_t e;
    e = raw;
    case (ctl)
      ALU_NOOP: begin
        e.res    = 32'h0;
        e.zero   = 1'b1;
        e.reg_wr = 1'b0;
      end
      ALU_AND, ALU_OR, ALU_ADD, ALU_XOR, ALU_SLL,
      ALU_SRL, ALU_SUB, ALU_SLT, ALU_NOR: ;
      default: e.reg_wr = 1'b0;
    endcase
    if (kill_wr) e.reg_wr = 1'b0;
    return e;
  endfunction

  entry_t head_q, head_d, skid_q, skid_d, in_ent;
  logic   head_vld_q, head_vld_d, skid_vld_q, skid_vld_d;
  logic   in_rdy_q, in_rdy_d;
  logic   accept, store, drain, ovf_kill;
  logic   pend_q, pend_d;

  assign accept = bus.in_valid && in_rdy_q;
  assign store  = accept && !bus.flush && !pend_q;
  assign drain  = head_vld_q && bus.out_ready;

  assign in_ent = sanitise('{res: bus.alu_res, zero: bus.zero, rd: bus.rd_addr,
                             reg_wr: bus.reg_wr, pc: bus.pc},
                           bus.alu_ctl, ovf_kill);

`ifdef OVF_TRAP_EN
  logic        trap_q, trap_d, ovf_hit;
  logic [31:0] epc_q, epc_d;

  assign ovf_kill = bus.ovf && is_addsub(bus.alu_ctl);
  assign ovf_hit  = store && ovf_kill;

  // Trap bookkeeping: one-cycle pulse, epc capture, squash until flush
  always_comb begin
    trap_d = ovf_hit;
    epc_d  = ovf_hit ? bus.pc : epc_q;
    pend_d = bus.flush ? 1'b0 : (pend_q || ovf_hit);
  end

  // Trap state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trap_q <= 1'b0;
      epc_q  <= 32'h0;
      pend_q <= 1'b0;
    end else begin
      trap_q <= trap_d;
      epc_q  <= epc_d;
      pend_q <= pend_d;
    end
  end

  assign bus.trap = trap_q;
  assign bus.epc  = epc_q;
`else
  logic unused_ovf;
  assign unused_ovf = bus.ovf ^ is_addsub(bus.alu_ctl);
  assign ovf_kill   = 1'b0;
  assign pend_q     = 1'b0;
  assign pend_d     = 1'b0;
  assign bus.trap   = 1'b0;
  assign bus.epc    = 32'h0;
`endif

  // Head/skid next state: flush empties; drain promotes skid; accept fills
  always_comb begin
    head_d     = head_q;
    skid_d     = skid_q;
    head_vld_d = head_vld_q;
    skid_vld_d = skid_vld_q;
    if (bus.flush) begin
      head_vld_d = 1'b0;
      skid_vld_d = 1'b0;
    end else if (drain) begin
      if (skid_vld_q) begin
        head_d     = skid_q;
        head_vld_d = 1'b1;
        skid_vld_d = store;
        if (store) skid_d = in_ent;
      end else if (store) begin
        head_d     = in_ent;
        head_vld_d = 1'b1;
      end else begin
        head_vld_d = 1'b0;
      end
    end else if (store) begin
      if (!head_vld_q) begin
        head_d     = in_ent;
        head_vld_d = 1'b1;
      end else begin
        skid_d     = in_ent;
        skid_vld_d = 1'b1;
      end
    end
    // Registered ready: never depends combinationally on out_ready
    in_rdy_d = !skid_vld_d || pend_d;
  end

  // Storage and ready registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q     <= '0;
      skid_q     <= '0;
      head_vld_q <= 1'b0;
      skid_vld_q <= 1'b0;
      in_rdy_q   <= 1'b1;
    end else begin
      head_q     <= head_d;
      skid_q     <= skid_d;
      head_vld_q <= head_vld_d;
      skid_vld_q <= skid_vld_d;
      in_rdy_q   <= in_rdy_d;
    end
  end

  assign bus.in_ready   = in_rdy_q;
  assign bus.out_valid  = head_vld_q;
  assign bus.out_res    = head_q.res;
  assign bus.out_zero   = head_q.zero;
  assign bus.out_rd     = head_q.rd;
  assign bus.out_reg_wr = head_q.reg_wr;
  assign bus.out_pc     = head_q.pc;

endmodule
